wr_full: RTL and testbench
==========================

Name: wr_full

Overview:
- Write-side pointer and full-flag logic for the async FIFO, in the write clock domain. Counterpart of the read-side empty logic.
- Keeps the binary and Gray write pointers and drives the memory write address and write strobe.
- Compares against the read pointer after it has passed through the 2-flop synchronizer into the write domain, and produces a registered full flag.
- Also produces a registered fill-level estimate, an almost-full flag and a sticky overflow flag.

Parameters:
- ADDR_SIZE, 4, memory address width; FIFO depth = 2**ADDR_SIZE; must be >= 2.
- ALMOST_FULL_THRESH, 12, fill level at or above which wr_almost_full asserts; valid range 1..2**ADDR_SIZE.

Ports:
- wr_clk  in  1  write-domain clock.
- wr_rst  in  1  synchronous, active-high reset on wr_clk.
- wr_inc  in  1  write request from the producer.
- rd_q2_ptr  in  ADDR_SIZE+1  Gray read pointer, already synchronized into wr_clk.
- wr_ovf_clr  in  1  clears the sticky overflow flag.
- wr_ptr  out  ADDR_SIZE+1  registered Gray write pointer, sent to the read-domain synchronizer.
- wr_addr  out  ADDR_SIZE  memory write address = wr_bin[ADDR_SIZE-1:0].
- wr_wen  out  1  memory write strobe = wr_inc & ~wr_full (combinational).
- wr_full  out  1  registered full flag.
- wr_almost_full  out  1  registered almost-full flag.
- wr_level  out  ADDR_SIZE+1  registered fill estimate, 0..2**ADDR_SIZE.
- wr_overflow  out  1  sticky flag: a write was attempted while full.

Behaviour:
- Clock and reset:
  - One clock, wr_clk.
  - Reset is synchronous and active-high on wr_rst, sampled only at the wr_clk rising edge.
  - While wr_rst is high at an edge: wr_bin, wr_ptr, wr_addr, wr_level = 0; wr_full, wr_almost_full, wr_overflow = 0.
  - wr_inc is ignored during reset; wr_wen still follows its equation.
- Pointer update:
  - wr_bin_next = wr_bin + (wr_inc & ~wr_full), modulo 2**(ADDR_SIZE+1).
  - wr_gray_next = (wr_bin_next >> 1) ^ wr_bin_next.
  - Both are registered every edge.
  - wr_ptr and wr_bin wrap from all-ones to 0 with no special handling.
- Full flag:
  - Full condition: wr_gray_next == {~rd_q2_ptr[ADDR_SIZE:ADDR_SIZE-1], rd_q2_ptr[ADDR_SIZE-2:0]}.
  - Registered, so wr_full is set at the same edge that accepts the write which fills the FIFO. No write is ever accepted beyond depth.
  - Deassertion is pessimistic. It happens one wr_clk after rd_q2_ptr advances, which is at least 3 wr_clk after the actual read because of the synchronizer.
- Level:
  - rd_q2_bin = Gray-to-binary(rd_q2_ptr), computed by an XOR prefix from the MSB down.
  - wr_level <= (wr_bin_next - rd_q2_bin) mod 2**(ADDR_SIZE+1).
  - The result never exceeds 2**ADDR_SIZE.
- Almost-full:
  - wr_almost_full <= (next level >= ALMOST_FULL_THRESH).
  - It is implied whenever wr_full is set.
- Overflow:
  - wr_overflow <= 1 when wr_inc & wr_full at the edge.
  - Otherwise wr_overflow <= 0 when wr_ovf_clr is high.
  - Set has priority over clear in the same cycle.
  - A rejected write leaves wr_bin, wr_ptr and the memory untouched.
- Simultaneous write and read:
  - Accept a write and see rd_q2_ptr advance in the same cycle: full and level are evaluated on both new values.
  - Net level is unchanged.
- Reset mid-operation: all state returns to the reset values at the next edge. Memory contents are don't-care.

Optional Feature:
- WR_ALMOST_FULL_EN defined: wr_level compare and wr_almost_full register are built as specified above.
- Not defined: wr_almost_full is tied to 0 and the threshold comparator is omitted. wr_level, wr_full and wr_overflow are unaffected.

Test Plan:
All scenarios use ADDR_SIZE=4, ALMOST_FULL_THRESH=12 and WR_ALMOST_FULL_EN defined.
1. Reset: hold wr_rst=1 for 2 cycles with wr_inc=1 -> wr_ptr=0, wr_addr=0, wr_full=0, wr_level=0, wr_overflow=0, no pointer movement.
2. Fill: rd_q2_ptr=0, wr_inc=1 for 17 cycles.
   - wr_addr steps 0..15.
   - After the 12th accepted write: wr_almost_full=1.
   - After the 16th: wr_full=1, wr_ptr=5'b11000, wr_level=16.
   - 17th cycle: wr_wen=0, wr_ptr unchanged, wr_overflow=1.
3. Release: from full, set rd_q2_ptr=5'b00110 (bin 4), wr_inc=0 -> next edge wr_full=0, wr_level=12, wr_almost_full=1. Then pulse wr_ovf_clr -> wr_overflow=0.
4. Wrap: continuous writes with rd_q2_ptr trailing by 3 entries, 40 writes total.
   - wr_addr wraps 15->0.
   - wr_ptr goes 5'b10000 -> 5'b00000 at bin 31->0.
   - wr_full is never set; wr_level stays 3.
5. Overflow priority: full, wr_inc=1 and wr_ovf_clr=1 in the same cycle -> wr_overflow=1.
6. Mid-operation reset: at wr_level=9, assert wr_rst with wr_inc=1 -> next edge wr_ptr=0, wr_level=0, all flags 0.

Source files
------------

// File: rtl/wr_full_if.sv
// Write-side FIFO control bundle: producer handshake, synchronized read pointer,
// and the pointer/status outputs of wr_full.
interface wr_full_if #(
  parameter int ADDR_SIZE = 4
);
  logic                 wr_inc;
  logic [ADDR_SIZE:0]   rd_q2_ptr;
  logic                 wr_ovf_clr;
  logic [ADDR_SIZE:0]   wr_ptr;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic                 wr_wen;
  logic                 wr_full;
  logic                 wr_almost_full;
  logic [ADDR_SIZE:0]   wr_level;
  logic                 wr_overflow;

  modport master (
    output wr_inc, rd_q2_ptr, wr_ovf_clr,
    input  wr_ptr, wr_addr, wr_wen, wr_full, wr_almost_full, wr_level, wr_overflow
  );

  modport slave (
    input  wr_inc, rd_q2_ptr, wr_ovf_clr,
    output wr_ptr, wr_addr, wr_wen, wr_full, wr_almost_full, wr_level, wr_overflow
  );
endinterface

// File: rtl/wr_full.sv
// Async FIFO write-side pointer, full flag, fill level and sticky overflow.
// Optional WR_ALMOST_FULL_EN builds the almost-full comparator and register.
module wr_full #(
  parameter int ADDR_SIZE          = 4,
  parameter int ALMOST_FULL_THRESH = 12
) (
  input logic     wr_clk,
  input logic     wr_rst,
  wr_full_if.slave bus
);

  if (ADDR_SIZE < 2) begin : g_bad_addr
    $error("wr_full: ADDR_SIZE must be >= 2");
  end
  if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > (1 << ADDR_SIZE)) begin : g_bad_thresh
    $error("wr_full: ALMOST_FULL_THRESH out of range");
  end

  logic [ADDR_SIZE:0] wr_bin;
  logic [ADDR_SIZE:0] gray_q;
  logic               full_q;
  logic [ADDR_SIZE:0] level_q;
  logic               ovf_q;

  logic               accept;
  logic [ADDR_SIZE:0] bin_next;
  logic [ADDR_SIZE:0] gray_next;
  logic [ADDR_SIZE:0] rd_q2_bin;
  logic [ADDR_SIZE:0] full_cmp;
  logic [ADDR_SIZE:0] level_next;

  always_comb begin
    accept     = bus.wr_inc & ~full_q;
    bin_next   = wr_bin + {{ADDR_SIZE{1'b0}}, accept};
    gray_next  = (bin_next >> 1) ^ bin_next;
    // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
    rd_q2_bin  = '0;
    for (int unsigned i = 0; i <= ADDR_SIZE; i++) begin
      rd_q2_bin[i] = ^(bus.rd_q2_ptr >> i);
    end
    full_cmp   = {~bus.rd_q2_ptr[ADDR_SIZE:ADDR_SIZE-1], bus.rd_q2_ptr[ADDR_SIZE-2:0]};
    level_next = bin_next - rd_q2_bin;
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wr_bin  <= '0;
      gray_q  <= '0;
      full_q  <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_bin  <= bin_next;
      gray_q  <= gray_next;
      full_q  <= (gray_next == full_cmp);
      level_q <= level_next;
      if (bus.wr_inc && full_q) begin
        ovf_q <= 1'b1;
      end else if (bus.wr_ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

`ifdef WR_ALMOST_FULL_EN
  localparam logic [ADDR_SIZE:0] THRESH = (ADDR_SIZE + 1)'(ALMOST_FULL_THRESH);
  logic af_q;

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      af_q <= 1'b0;
    end else begin
      af_q <= (level_next >= THRESH);
    end
  end

  assign bus.wr_almost_full = af_q;
`else
  assign bus.wr_almost_full = 1'b0;
`endif

  assign bus.wr_ptr      = gray_q;
  assign bus.wr_addr     = wr_bin[ADDR_SIZE-1:0];
  assign bus.wr_wen      = bus.wr_inc & ~full_q;
  assign bus.wr_full     = full_q;
  assign bus.wr_level    = level_q;
  assign bus.wr_overflow = ovf_q;

endmodule

// File: tb/tb_wr_full.sv
// Randomized and directed bench for wr_full against an occupancy-count model:
// total writes and reads are tracked as plain integers.
module tb_wr_full;
  localparam int A     = 4;
  localparam int TH    = 12;
  localparam int DEPTH = 1 << A;

  logic wr_clk = 1'b0;
  logic wr_rst = 1'b1;

  wr_full_if #(.ADDR_SIZE(A)) bus ();

  wr_full #(.ADDR_SIZE(A), .ALMOST_FULL_THRESH(TH)) dut (
    .wr_clk (wr_clk),
    .wr_rst (wr_rst),
    .bus    (bus)
  );

  always #5 wr_clk = ~wr_clk;

  int checks = 0;
  int errors = 0;

  // Model state: totals since reset, plus flags.
  int wtot = 0;
  int rtot = 0;
  bit m_full = 0;
  bit m_af = 0;
  bit m_ovf = 0;
  int m_level = 0;

  function automatic logic [A:0] to_gray(input int v);
    logic [A:0] b;
    b = v[A:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One write-clock cycle: the read side advances by rd_adv before the edge.
  task automatic step(input bit inc, input bit clr, input bit rst, input int rd_adv);
    bit acc;
    rtot += rd_adv;
    bus.wr_inc     = inc;
    bus.wr_ovf_clr = clr;
    bus.rd_q2_ptr  = to_gray(rtot);
    wr_rst         = rst;
    #1;
    check("wen", {31'b0, bus.wr_wen}, {31'b0, inc && !m_full});
    @(posedge wr_clk);
    if (rst) begin
      wtot = 0; rtot = 0; m_full = 0; m_af = 0; m_ovf = 0; m_level = 0;
    end else begin
      acc = inc && !m_full;
      if (inc && m_full) m_ovf = 1;
      else if (clr) m_ovf = 0;
      wtot += int'(acc);
      m_level = wtot - rtot;
      m_full  = (m_level == DEPTH);
`ifdef WR_ALMOST_FULL_EN
      m_af    = (m_level >= TH);
`else
      m_af    = 0;
`endif
    end
    #1;
    check("ptr",   {27'b0, bus.wr_ptr},   {27'b0, to_gray(wtot)});
    check("addr",  {28'b0, bus.wr_addr},  32'(wtot % DEPTH));
    check("full",  {31'b0, bus.wr_full},  {31'b0, m_full});
    check("level", {27'b0, bus.wr_level}, 32'(m_level));
    check("af",    {31'b0, bus.wr_almost_full}, {31'b0, m_af});
    check("ovf",   {31'b0, bus.wr_overflow},    {31'b0, m_ovf});
  endtask

  initial begin
    int guard;
    int room;
    bus.wr_inc     = 1'b1;
    bus.wr_ovf_clr = 1'b0;
    bus.rd_q2_ptr  = '0;

    // Reset with writes requested: nothing may move.
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    check("rst_ptr", {27'b0, bus.wr_ptr}, 32'd0);

    // Fill 16 entries, then one rejected write.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0);
    check("fill_ptr",   {27'b0, bus.wr_ptr},   32'h18);
    check("fill_level", {27'b0, bus.wr_level}, 32'd16);
    step(1, 0, 0, 0);
    check("fill_ovf",   {31'b0, bus.wr_overflow}, 32'd1);
    check("fill_hold",  {27'b0, bus.wr_ptr},      32'h18);

    // Read side reaches binary 4: full releases, level 12.
    step(0, 0, 0, 4);
    check("rel_level", {27'b0, bus.wr_level}, 32'd12);
    step(0, 1, 0, 0);
    check("rel_ovf", {31'b0, bus.wr_overflow}, 32'd0);

    // Trail by 3 and stream 40 writes through the pointer wrap.
    step(0, 0, 0, 9);
    for (int i = 0; i < 40; i++) step(1, 0, 0, 1);
    check("wrap_level", {27'b0, bus.wr_level}, 32'd3);

    // Fill again, then set and clear in the same cycle: set wins.
    guard = 0;
    while (!m_full && guard < 40) begin
      step(1, 0, 0, 0);
      guard++;
    end
    check("refill_full", {31'b0, bus.wr_full}, 32'd1);
    step(1, 1, 0, 0);
    check("ovf_prio", {31'b0, bus.wr_overflow}, 32'd1);

    // Reset in the middle of traffic at level 9.
    step(0, 0, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
    check("mid_level", {27'b0, bus.wr_level}, 32'd9);
    step(1, 0, 1, 0);
    check("mid_rst_level", {27'b0, bus.wr_level}, 32'd0);

    // Random traffic with occasional clear and reset.
    for (int i = 0; i < 500; i++) begin
      room = wtot - rtot;
      if (room > 3) room = 3;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 99) == 0), $urandom_range(0, room) * int'($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
